// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: source and load-size encodings,
// plus elaboration-time helpers for the datapath width.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_EXE  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC   = 2'd2,
    WB_SEL_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_BYTE  = 2'd0,
    LD_HALF  = 2'd1,
    LD_WORD  = 2'd2,
    LD_DWORD = 2'd3
  } ld_size_e;

  localparam int unsigned WB_NUM_SRC = 4;

  function automatic bit width_legal(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

  // Number of exe_out bits that address a byte within one memory word.
  function automatic int unsigned off_bits(input int unsigned w);
    return (w == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/ld_align.sv
// Combinational load aligner: picks the addressed bytes out of an aligned
// memory word, sign/zero-extends them and flags misaligned accesses.
module ld_align
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             mem_word_i,
  input  logic [$clog2(WIDTH/8)-1:0]   offset_i,
  input  logic [1:0]                   size_i,
  input  logic                         unsigned_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         misalign_o
);

  localparam int OFFW = $clog2(WIDTH/8);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [OFFW+2:0]  shift_amt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mask;
  logic [OFFW-1:0]  align_mask;
  logic             sign_bit;
  logic             ext_bit;
  int               nbits;

  // NOTE: every signal driven here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    shift_amt  = {offset_i, 3'b000};
    shifted    = mem_word_i >> shift_amt;
    nbits      = 8 << size_i;
    if (nbits > WIDTH) nbits = WIDTH;
    mask       = ONES >> (WIDTH - nbits);
    // Top bit of the extracted field is the only bit set in mask & ~(mask >> 1).
    sign_bit   = |(shifted & mask & ~(mask >> 1));
    ext_bit    = ~unsigned_i & sign_bit;
    data_o     = (shifted & mask) | ({WIDTH{ext_bit}} & ~mask);
    align_mask = OFFW'((32'd1 << size_i) - 32'd1);
    misalign_o = (|(offset_i & align_mask)) ||
                 ((size_i == LD_DWORD) && (WIDTH == 32));
  end

endmodule

// File: rtl/param_mux.sv
// Generic N-input, WIDTH-bit multiplexer shared across the pipeline.
module param_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic [N-1:0][WIDTH-1:0] in_i,
  input  logic [$clog2(N)-1:0]    sel_i,
  output logic [WIDTH-1:0]        out_o
);

  assign out_o = in_i[sel_i];

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: selects the result source, aligns load data and
// registers the register-file write with one cycle of latency.
module wb_stage
  import wb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RIDX  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] exe_out,
  input  logic [WIDTH-1:0] mem_out,
  input  logic [WIDTH-1:0] pc_plus,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       wb_sel,
  input  logic [1:0]       ld_size,
  input  logic             ld_unsigned,
  input  logic [RIDX-1:0]  rd_in,
  input  logic             we_in,
  output logic [WIDTH-1:0] wb_data,
  output logic [RIDX-1:0]  wb_rd,
  output logic             wb_we,
  output logic             wb_valid,
  output logic             misalign
);

  localparam int OFFW = off_bits(WIDTH);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("wb_stage: WIDTH must be 32 or 64");
  end

  logic [WIDTH-1:0]                    ld_data;
  logic                                ld_mis;
  logic [WB_NUM_SRC-1:0][WIDTH-1:0]    src;
  logic [WIDTH-1:0]                    sel_data;
  logic                                is_load;
  logic                                mis_now;
  logic                                we_now;

  logic [WIDTH-1:0] data_q,  data_d;
  logic [RIDX-1:0]  rd_q,    rd_d;
  logic             we_q,    we_d;
  logic             valid_q, valid_d;
  logic             mis_q,   mis_d;

  ld_align #(.WIDTH(WIDTH)) u_ld_align (
    .mem_word_i (mem_out),
    .offset_i   (exe_out[OFFW-1:0]),
    .size_i     (ld_size),
    .unsigned_i (ld_unsigned),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );

  assign src[WB_SEL_EXE]  = exe_out;
  assign src[WB_SEL_LOAD] = ld_data;
  assign src[WB_SEL_PC]   = pc_plus;
  assign src[WB_SEL_IMM]  = imm;

  param_mux #(.WIDTH(WIDTH), .N(WB_NUM_SRC)) u_src_mux (
    .in_i  (src),
    .sel_i (wb_sel),
    .out_o (sel_data)
  );

  assign is_load  = (wb_sel == WB_SEL_LOAD);
  assign mis_now  = is_load & ld_mis;
  assign we_now   = in_valid & we_in & (|rd_in) & ~mis_now;
  assign in_ready = ~stall;

  // Flush beats stall; data and rd simply hold on a flush since they are
  // meaningless once valid is cleared.
  always_comb begin
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (flush) begin
      we_d    = 1'b0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (!stall) begin
      data_d  = sel_data;
      rd_d    = rd_in;
      we_d    = we_now;
      valid_d = in_valid;
      mis_d   = mis_now;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign wb_data  = data_q;
  assign wb_rd    = rd_q;
  assign wb_we    = we_q;
  assign wb_valid = valid_q;
  assign misalign = mis_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage at WIDTH 32: data paths, load
// extraction, misalignment, x0 suppression, stall, flush and async reset.
module tb_wb_stage;

  localparam int WIDTH = 32;
  localparam int RIDX  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] exe_out;
  logic [WIDTH-1:0] mem_out;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] imm;
  logic [1:0]       wb_sel;
  logic [1:0]       ld_size;
  logic             ld_unsigned;
  logic [RIDX-1:0]  rd_in;
  logic             we_in;
  logic [WIDTH-1:0] wb_data;
  logic [RIDX-1:0]  wb_rd;
  logic             wb_we;
  logic             wb_valid;
  logic             misalign;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage #(.WIDTH(WIDTH), .RIDX(RIDX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .exe_out     (exe_out),
    .mem_out     (mem_out),
    .pc_plus     (pc_plus),
    .imm         (imm),
    .wb_sel      (wb_sel),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .rd_in       (rd_in),
    .we_in       (we_in),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .wb_valid    (wb_valid),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [1:0] sz,
                       input logic uns, input logic [31:0] exe, input logic [31:0] mem,
                       input logic [4:0] rd, input logic we);
    in_valid    = v;
    wb_sel      = sel;
    ld_size     = sz;
    ld_unsigned = uns;
    exe_out     = exe;
    mem_out     = mem;
    rd_in       = rd;
    we_in       = we;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    pc_plus = 32'h0000_0100; imm = 32'hCAFE_0000;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h5555_5555, 32'h0, 5'd9, 1'b1);
    #1;
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want %h", wb_data, 32'h0); end
    n_checks++; if ({wb_rd, wb_we, wb_valid, misalign} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got rd=%h we=%b v=%b mis=%b want all 0", wb_rd, wb_we, wb_valid, misalign); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    // Edges under reset must not capture anything.
    step();
    n_checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_hold: got v=%b data=%h want 0/0", wb_valid, wb_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_path();
    drive(1'b1, 2'd0, 2'd3, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 1'b1);
    step();
    n_checks++; if (wb_data !== 32'h0000_1234) begin n_fail++; $display("FAIL word_data: got %h want %h", wb_data, 32'h1234); end
    n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL word_rd: got %0d want 5", wb_rd); end
    n_checks++; if (wb_we !== 1'b1 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL word_we_valid: got we=%b v=%b want 1/1", wb_we, wb_valid); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL word_mis: got %b want 0", misalign); end
    // pc_plus and imm sources; an odd offset with ld_size half must not flag.
    pc_plus = 32'h0000_0104;
    drive(1'b1, 2'd2, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 5'd1, 1'b1);
    step();
    n_checks++; if (wb_data !== 32'h0000_0104 || misalign !== 1'b0) begin n_fail++; $display("FAIL pc_path: got %h mis=%b want 00000104 mis=0", wb_data, misalign); end
    drive(1'b1, 2'd3, 2'd3, 1'b0, 32'h0000_0003, 32'h0, 5'd31, 1'b1);
    step();
    n_checks++; if (wb_data !== 32'hCAFE_0000 || wb_rd !== 5'd31 || misalign !== 1'b0) begin n_fail++; $display("FAIL imm_path: got %h rd=%0d mis=%b want cafe0000 rd=31 mis=0", wb_data, wb_rd, misalign); end
  endtask

  task automatic test_load_extract();
    logic [31:0] mem_word;
    logic [31:0] exp_tab [6];
    logic [1:0]  off_tab [6];
    logic [1:0]  sz_tab  [6];
    logic        uns_tab [6];
    mem_word = 32'h80FF_7F01;
    off_tab[0] = 2'd3; sz_tab[0] = 2'd0; uns_tab[0] = 1'b0; exp_tab[0] = 32'hFFFF_FF80;
    off_tab[1] = 2'd2; sz_tab[1] = 2'd1; uns_tab[1] = 1'b1; exp_tab[1] = 32'h0000_80FF;
    off_tab[2] = 2'd2; sz_tab[2] = 2'd1; uns_tab[2] = 1'b0; exp_tab[2] = 32'hFFFF_80FF;
    off_tab[3] = 2'd1; sz_tab[3] = 2'd0; uns_tab[3] = 1'b0; exp_tab[3] = 32'h0000_007F;
    off_tab[4] = 2'd3; sz_tab[4] = 2'd0; uns_tab[4] = 1'b1; exp_tab[4] = 32'h0000_0080;
    off_tab[5] = 2'd0; sz_tab[5] = 2'd2; uns_tab[5] = 1'b0; exp_tab[5] = 32'h80FF_7F01;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd1, sz_tab[i], uns_tab[i], {28'h0000_100, 2'b00, off_tab[i]}, mem_word, 5'd10, 1'b1);
      step();
      n_checks++;
      if (wb_data !== exp_tab[i] || misalign !== 1'b0 || wb_we !== 1'b1) begin
        n_fail++;
        $display("FAIL load_vec%0d: got data=%h mis=%b we=%b want data=%h mis=0 we=1", i, wb_data, misalign, wb_we, exp_tab[i]);
      end
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 2'd1, 2'd1, 1'b0, 32'h0000_0001, 32'h80FF_7F01, 5'd6, 1'b1);
    step();
    n_checks++; if (misalign !== 1'b1 || wb_we !== 1'b0 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL mis_half: got mis=%b we=%b v=%b want 1/0/1", misalign, wb_we, wb_valid); end
    drive(1'b1, 2'd1, 2'd2, 1'b0, 32'h0000_0002, 32'h80FF_7F01, 5'd6, 1'b1);
    step();
    n_checks++; if (misalign !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL mis_word: got mis=%b we=%b want 1/0", misalign, wb_we); end
    drive(1'b1, 2'd1, 2'd3, 1'b0, 32'h0000_0000, 32'h80FF_7F01, 5'd6, 1'b1);
    step();
    n_checks++; if (misalign !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL mis_dword32: got mis=%b we=%b want 1/0", misalign, wb_we); end
    drive(1'b1, 2'd1, 2'd1, 1'b0, 32'h0000_0002, 32'h80FF_7F01, 5'd6, 1'b1);
    step();
    n_checks++; if (misalign !== 1'b0 || wb_we !== 1'b1) begin n_fail++; $display("FAIL aligned_half: got mis=%b we=%b want 0/1", misalign, wb_we); end
  endtask

  task automatic test_x0_stall();
    logic [31:0] held_data;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_AAAA, 32'h0, 5'd0, 1'b1);
    step();
    n_checks++; if (wb_we !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'h0000_AAAA) begin n_fail++; $display("FAIL x0_we: got we=%b v=%b data=%h want 0/1/0000aaaa", wb_we, wb_valid, wb_data); end
    drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_BBBB, 32'h0, 5'd7, 1'b1);
    step();
    held_data = 32'h0000_BBBB;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(c[0], 2'd1, 2'd1, 1'b0, 32'h1 + c, 32'hF0F0_0000 + c, 5'd20 + 5'(c), 1'b1);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 0", c, in_ready); end
      step();
      n_checks++;
      if (wb_data !== held_data || wb_rd !== 5'd7 || wb_we !== 1'b1 || wb_valid !== 1'b1 || misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got data=%h rd=%0d we=%b v=%b mis=%b want %h/7/1/1/0", c, wb_data, wb_rd, wb_we, wb_valid, misalign, held_data);
      end
    end
    stall = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready: got %b want 1", in_ready); end
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h0000_CCCC, 32'h0, 5'd8, 1'b1);
    step();
    n_checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL bubble: got v=%b we=%b want 0/0", wb_valid, wb_we); end
  endtask

  task automatic test_flush();
    drive(1'b1, 2'd1, 2'd1, 1'b0, 32'h0000_0003, 32'h1234_5678, 5'd4, 1'b1);
    step();
    n_checks++; if (misalign !== 1'b1 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL preflush: got mis=%b v=%b want 1/1", misalign, wb_valid); end
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_0011, 32'h0, 5'd3, 1'b1);
    step();
    n_checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got v=%b we=%b mis=%b want 0/0/0", wb_valid, wb_we, misalign); end
    stall = 1'b0;
    step();
    n_checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL flush_only: got v=%b we=%b want 0/0", wb_valid, wb_we); end
    flush = 1'b0;
    step();
    n_checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== 32'h0000_0011 || wb_rd !== 5'd3) begin n_fail++; $display("FAIL post_flush: got v=%b we=%b data=%h rd=%0d want 1/1/00000011/3", wb_valid, wb_we, wb_data, wb_rd); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'd3, 2'd0, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1);
    imm = 32'h7777_7777;
    step();
    n_checks++; if (wb_data !== 32'h7777_7777 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL prereset: got data=%h v=%b want 77777777/1", wb_data, wb_valid); end
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_we !== 1'b0 || wb_valid !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%h rd=%0d we=%b v=%b mis=%b want all 0", wb_data, wb_rd, wb_we, wb_valid, misalign);
    end
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_0ABC, 32'h0, 5'd2, 1'b1);
    step();
    n_checks++; if (wb_data !== 32'h0000_0ABC || wb_rd !== 5'd2 || wb_we !== 1'b1) begin n_fail++; $display("FAIL first_capture: got data=%h rd=%0d we=%b want 00000abc/2/1", wb_data, wb_rd, wb_we); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_0001, 32'h0, 5'd1, 1'b1);
    step();
    drive(1'b1, 2'd1, 2'd0, 1'b1, 32'h0000_0000, 32'h0000_00F3, 5'd2, 1'b1);
    n_checks++; if (wb_data !== 32'h1 || wb_rd !== 5'd1) begin n_fail++; $display("FAIL b2b_0: got data=%h rd=%0d want 1/1", wb_data, wb_rd); end
    step();
    n_checks++; if (wb_data !== 32'h0000_00F3 || wb_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_1: got data=%h rd=%0d want 000000f3/2", wb_data, wb_rd); end
  endtask

  initial begin
    test_reset();
    test_word_path();
    test_load_extract();
    test_misalign();
    test_x0_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter RIDX, default 5, register-index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  MEM-side result present this cycle.
REQ-006 SHALL have port in_ready  output  1  stage accepts input; equals !stall.
REQ-007 SHALL have port stall  input  1  hold all stage registers.
REQ-008 SHALL have port flush  input  1  kill the held entry and the accepted input.
REQ-009 SHALL have port exe_out  input  WIDTH  ALU result; low bits give the load byte offset.
REQ-010 SHALL have port mem_out  input  WIDTH  raw aligned memory word.
REQ-011 SHALL have port pc_plus  input  WIDTH  link address.
REQ-012 SHALL have port imm  input  WIDTH  immediate for direct writes.
REQ-013 SHALL have port wb_sel  input  2  0 exe_out, 1 load data, 2 pc_plus, 3 imm.
REQ-014 SHALL have port ld_size  input  2  0 byte, 1 half, 2 word, 3 dword.
REQ-015 SHALL have port ld_unsigned  input  1  1 zero-extends loads, 0 sign-extends loads.
REQ-016 SHALL have port rd_in  input  RIDX  destination register.
REQ-017 SHALL have port we_in  input  1  register write request.
REQ-018 SHALL have port wb_data  output  WIDTH  registered write-back value.
REQ-019 SHALL have port wb_rd  output  RIDX  registered destination.
REQ-020 SHALL have port wb_we  output  1  registered register-file write enable.
REQ-021 SHALL have port wb_valid  output  1  registered entry valid.
REQ-022 SHALL have port misalign  output  1  registered misaligned-load flag.

Function
REQ-023 Load data SHALL be extracted from mem_out at byte offset exe_out[log2(WIDTH/8)-1:0], then extended to WIDTH per ld_unsigned.
REQ-024 A load SHALL be misaligned when its offset is not a multiple of its size in bytes; ld_size 3 with WIDTH 32 SHALL also count as misaligned.
REQ-025 A load SHALL be a cycle with wb_sel 1.
REQ-026 On a rising edge with stall 0, the stage SHALL capture the selected value, rd_in, in_valid and misalign; latency is exactly 1 cycle.
REQ-027 wb_we SHALL be in_valid & we_in & (rd_in != 0) & !misalign, computed at capture.
REQ-028 With stall 1, all outputs SHALL hold and in_ready SHALL be 0.
REQ-029 With flush 1, the next edge SHALL clear wb_valid, wb_we and misalign, whatever the value of stall; flush wins over stall.
REQ-030 With flush 1, wb_data and wb_rd SHALL be left as don't-care.
REQ-031 With in_valid 0 and stall 0, the next edge SHALL clear wb_valid and wb_we.
REQ-032 For wb_sel 0, 2 and 3, ld_size and ld_unsigned SHALL be ignored and misalign SHALL be 0.

Reset
REQ-033 rst_n low SHALL immediately force wb_data 0, wb_rd 0, wb_we 0, wb_valid 0 and misalign 0, independent of clk.
REQ-034 Reset deassertion SHALL be synchronised externally; the first capture SHALL happen on the first edge with rst_n high.
REQ-035 Reset asserted during a stall SHALL still clear all state.

Structure
REQ-036 The wb_sel encodings, the ld_size encodings and the WIDTH legality check SHALL live in a shared package, wb_pkg.
REQ-037 Load alignment and extension SHALL be a combinational sub-module, ld_align, parameterised by WIDTH.
REQ-038 Source selection SHALL reuse the team's existing parameterised mux.

Verification
REQ-039 Scenario, word path: WIDTH 32, wb_sel 0, exe_out 0x1234, rd 5, we 1 -> next cycle wb_data 0x1234, wb_rd 5, wb_we 1.
REQ-040 Scenario, signed byte: wb_sel 1, ld_size 0, signed, mem_out 0x80FF7F01, exe_out low 2 bits 3 -> wb_data 0xFFFFFF80.
REQ-041 Scenario, unsigned half: same inputs with ld_size 1, unsigned, offset 2 -> wb_data 0x000080FF.
REQ-042 Scenario, misaligned half: ld_size 1, offset 1 -> misalign 1, wb_we 0, wb_valid 1.
REQ-043 Scenario, x0 and stall: rd 0, we 1 -> wb_we 0; then stall for 3 cycles with changing inputs -> outputs unchanged and in_ready 0.
REQ-044 Scenario, flush and reset: flush and stall together -> wb_valid 0 next cycle; rst_n pulsed low mid-cycle -> all outputs 0 before the next edge.
